// File: rtl/clock_ctrl_if.sv
// rtl/clock_ctrl_if.sv - button/tick inputs, counter feedback and counter control bundle for clock_ctrl
interface clock_ctrl_if #(
    parameter int SEC_BITS = 6,
    parameter int HR_BITS  = 5
);
    logic                tick;
    logic                btn_mode;
    logic                btn_up;
    logic                btn_down;
    logic [SEC_BITS-1:0] sec;
    logic [SEC_BITS-1:0] min;
    logic [HR_BITS-1:0]  hr;
    logic                sec_start;
    logic                sec_forward;
    logic                sec_clr;
    logic                min_start;
    logic                min_forward;
    logic                min_clr;
    logic                hr_start;
    logic                hr_forward;
    logic                hr_clr;
    logic [1:0]          mode;

    modport master (
        input  tick, btn_mode, btn_up, btn_down, sec, min, hr,
        output sec_start, sec_forward, sec_clr,
        output min_start, min_forward, min_clr,
        output hr_start, hr_forward, hr_clr, mode
    );

    modport slave (
        output tick, btn_mode, btn_up, btn_down, sec, min, hr,
        input  sec_start, sec_forward, sec_clr,
        input  min_start, min_forward, min_clr,
        input  hr_start, hr_forward, hr_clr, mode
    );
endinterface

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - run/set sequencer for the sec/min/hr counters of the digital clock
// Optional CLOCK_CTRL_SEC_CLR_EN: leaving SET_MIN also clears seconds.
module clock_ctrl #(
    parameter int SEC_BITS = 6,
    parameter int HR_BITS  = 5,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HR_MAX   = 23
) (
    input  logic          clk,
    input  logic          rst,
    clock_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    localparam logic [SEC_BITS-1:0] L_SEC_MAX = SEC_MAX[SEC_BITS-1:0];
    localparam logic [SEC_BITS-1:0] L_MIN_MAX = MIN_MAX[SEC_BITS-1:0];
    localparam logic [HR_BITS-1:0]  L_HR_MAX  = HR_MAX[HR_BITS-1:0];

    state_t r_state, w_state_nxt;
    logic   r_lock, r_init;
    logic   r_sec_start, r_sec_forward, r_sec_clr;
    logic   r_min_start, r_min_forward, r_min_clr;
    logic   r_hr_start, r_hr_forward, r_hr_clr;
    logic   w_sec_start, w_sec_forward, w_sec_clr;
    logic   w_min_start, w_min_forward, w_min_clr;
    logic   w_hr_start, w_hr_forward, w_hr_clr;
    logic   w_any_cmd;

    // Out-of-range feedback counts as "at MAX" so the next increment clears it.
    logic w_sec_max, w_min_max, w_hr_max, w_min_zero, w_hr_zero;
    logic w_tick_ok, w_adj_ok;

    assign w_sec_max  = (bus.sec >= L_SEC_MAX);
    assign w_min_max  = (bus.min >= L_MIN_MAX);
    assign w_hr_max   = (bus.hr >= L_HR_MAX);
    assign w_min_zero = (bus.min == '0);
    assign w_hr_zero  = (bus.hr == '0);
    assign w_tick_ok  = bus.tick & ~r_lock;
    assign w_adj_ok   = ~r_lock & ~bus.btn_mode & (bus.btn_up ^ bus.btn_down);

    always_comb begin
        w_state_nxt   = r_state;
        w_sec_start   = 1'b0;
        w_sec_forward = 1'b0;
        w_sec_clr     = 1'b0;
        w_min_start   = 1'b0;
        w_min_forward = 1'b0;
        w_min_clr     = 1'b0;
        w_hr_start    = 1'b0;
        w_hr_forward  = 1'b0;
        w_hr_clr      = 1'b0;

        if (r_init) begin
            w_sec_clr   = 1'b1;
            w_min_clr   = 1'b1;
            w_hr_clr    = 1'b1;
            w_state_nxt = RUN;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_tick_ok) begin
                        if (!w_sec_max) begin
                            w_sec_start   = 1'b1;
                            w_sec_forward = 1'b1;
                        end else begin
                            w_sec_clr = 1'b1;
                            if (!w_min_max) begin
                                w_min_start   = 1'b1;
                                w_min_forward = 1'b1;
                            end else begin
                                w_min_clr = 1'b1;
                                if (!w_hr_max) begin
                                    w_hr_start   = 1'b1;
                                    w_hr_forward = 1'b1;
                                end else begin
                                    w_hr_clr = 1'b1;
                                end
                            end
                        end
                    end
                    if (bus.btn_mode) w_state_nxt = SET_HR;
                end
                SET_HR: begin
                    if (bus.btn_mode) begin
                        w_state_nxt = SET_MIN;
                    end else if (w_adj_ok) begin
                        if (bus.btn_up) begin
                            if (w_hr_max) begin
                                w_hr_clr = 1'b1;
                            end else begin
                                w_hr_start   = 1'b1;
                                w_hr_forward = 1'b1;
                            end
                        end else if (!w_hr_zero) begin
                            w_hr_start = 1'b1;
                        end
                    end
                end
                SET_MIN: begin
                    if (bus.btn_mode) begin
                        w_state_nxt = RUN;
`ifdef CLOCK_CTRL_SEC_CLR_EN
                        w_sec_clr = 1'b1;
`else
                        w_sec_clr = 1'b0;
`endif
                    end else if (w_adj_ok) begin
                        if (bus.btn_up) begin
                            if (w_min_max) begin
                                w_min_clr = 1'b1;
                            end else begin
                                w_min_start   = 1'b1;
                                w_min_forward = 1'b1;
                            end
                        end else if (!w_min_zero) begin
                            w_min_start = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign w_any_cmd = w_sec_start | w_sec_clr | w_min_start | w_min_clr | w_hr_start | w_hr_clr;

    // r_lock blocks the sample after any command so the counter feedback has settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_lock        <= 1'b1;
            r_init        <= 1'b1;
            r_sec_start   <= 1'b0;
            r_sec_forward <= 1'b0;
            r_sec_clr     <= 1'b0;
            r_min_start   <= 1'b0;
            r_min_forward <= 1'b0;
            r_min_clr     <= 1'b0;
            r_hr_start    <= 1'b0;
            r_hr_forward  <= 1'b0;
            r_hr_clr      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lock        <= w_any_cmd;
            r_init        <= 1'b0;
            r_sec_start   <= w_sec_start;
            r_sec_forward <= w_sec_forward;
            r_sec_clr     <= w_sec_clr;
            r_min_start   <= w_min_start;
            r_min_forward <= w_min_forward;
            r_min_clr     <= w_min_clr;
            r_hr_start    <= w_hr_start;
            r_hr_forward  <= w_hr_forward;
            r_hr_clr      <= w_hr_clr;
        end
    end

    assign bus.sec_start   = r_sec_start;
    assign bus.sec_forward = r_sec_forward;
    assign bus.sec_clr     = r_sec_clr;
    assign bus.min_start   = r_min_start;
    assign bus.min_forward = r_min_forward;
    assign bus.min_clr     = r_min_clr;
    assign bus.hr_start    = r_hr_start;
    assign bus.hr_forward  = r_hr_forward;
    assign bus.hr_clr      = r_hr_clr;
    assign bus.mode        = r_state;
endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - directed and randomized bench for clock_ctrl with behavioural counters and time model
module tb_clock_ctrl;
    localparam int SB = 6;
    localparam int HB = 5;
`ifdef CLOCK_CTRL_SEC_CLR_EN
    localparam bit SCE = 1'b1;
`else
    localparam bit SCE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_ctrl_if #(.SEC_BITS(SB), .HR_BITS(HB)) bus ();

    clock_ctrl #(
        .SEC_BITS(SB), .HR_BITS(HB), .SEC_MAX(59), .MIN_MAX(59), .HR_MAX(23)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External counters: clear beats start; start steps up or down by forward.
    logic [SB-1:0] c_s, c_m;
    logic [HB-1:0] c_h;
    logic          load_req;
    logic [SB-1:0] ld_s, ld_m;
    logic [HB-1:0] ld_h;

    always @(posedge clk) begin
        if (load_req) begin
            c_s <= ld_s;
            c_m <= ld_m;
            c_h <= ld_h;
        end else begin
            if (bus.sec_clr) c_s <= '0;
            else if (bus.sec_start) c_s <= bus.sec_forward ? c_s + 1'b1 : c_s - 1'b1;
            if (bus.min_clr) c_m <= '0;
            else if (bus.min_start) c_m <= bus.min_forward ? c_m + 1'b1 : c_m - 1'b1;
            if (bus.hr_clr) c_h <= '0;
            else if (bus.hr_start) c_h <= bus.hr_forward ? c_h + 1'b1 : c_h - 1'b1;
        end
    end

    assign bus.sec = c_s;
    assign bus.min = c_m;
    assign bus.hr  = c_h;

    wire [8:0]  w_cmd  = {bus.sec_start, bus.sec_forward, bus.sec_clr,
                          bus.min_start, bus.min_forward, bus.min_clr,
                          bus.hr_start, bus.hr_forward, bus.hr_clr};
    wire [16:0] w_time = {c_h, c_m, c_s};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic m, input logic u, input logic d);
        bus.tick     = t;
        bus.btn_mode = m;
        bus.btn_up   = u;
        bus.btn_down = d;
        @(posedge clk);
        #1;
        bus.tick     = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
    endtask

    task automatic load(input int s, input int m, input int h);
        ld_s     = SB'(s);
        ld_m     = SB'(m);
        ld_h     = HB'(h);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    function automatic logic [16:0] pack(input int h, input int m, input int s);
        return {HB'(h), SB'(m), SB'(s)};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mh, mm, ms, mmode, tot;
        bit mlock, mcmd, acc;
        logic t, m, u, d;
        logic [16:0] prev;

        bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        load_req = 1'b0; ld_s = '0; ld_m = '0; ld_h = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        load(17, 33, 9);
        step(0, 0, 0, 0);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_cmds", 32'(w_cmd), 0);

        rst = 1'b0;
        step(0, 0, 0, 0);
        chk("init_clr", 32'(w_cmd), 9'b001_001_001);
        step(1, 0, 0, 0);
        chk("init_lock_tick", 32'(w_cmd), 0);
        chk("init_time", 32'(w_time), 0);

        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("tick_sec_start", 32'(w_cmd), 9'b110_000_000);
            step(0, 0, 0, 0);
        end
        chk("three_ticks_time", 32'(w_time), pack(0, 0, 3));
        chk("three_ticks_mode", 32'(bus.mode), 0);

        load(59, 59, 23);
        step(1, 0, 0, 0);
        chk("wrap_all_cmds", 32'(w_cmd), 9'b001_001_001);
        step(0, 0, 0, 0);
        chk("wrap_all_time", 32'(w_time), pack(0, 0, 0));

        load(59, 12, 5);
        step(1, 0, 0, 0);
        chk("sec_wrap_cmds", 32'(w_cmd), 9'b001_110_000);
        step(0, 0, 0, 0);
        chk("sec_wrap_time", 32'(w_time), pack(5, 13, 0));

        step(0, 1, 0, 0);
        chk("to_set_hr", 32'(bus.mode), 1);
        load(0, 13, 0);
        step(0, 0, 0, 1);
        chk("hr_down_at_zero", 32'(w_cmd), 0);
        load(0, 13, 23);
        step(0, 0, 1, 0);
        chk("hr_up_at_max", 32'(w_cmd), 9'b000_000_001);
        step(0, 0, 0, 0);
        chk("hr_up_wrap_val", 32'(c_h), 0);
        load(0, 13, 7);
        step(0, 0, 0, 1);
        chk("hr_down_cmds", 32'(w_cmd), 9'b000_000_100);
        step(0, 0, 0, 0);
        chk("hr_down_val", 32'(c_h), 6);
        step(0, 1, 1, 0);
        chk("mode_beats_up_cmds", 32'(w_cmd), 0);
        chk("to_set_min", 32'(bus.mode), 2);

        step(0, 0, 1, 1);
        chk("up_down_both", 32'(w_cmd), 0);
        step(1, 0, 0, 0);
        chk("tick_in_set", 32'(w_cmd), 0);
        step(0, 0, 1, 0);
        chk("min_up_cmds", 32'(w_cmd), 9'b000_110_000);
        step(0, 0, 1, 0);
        chk("min_up_locked", 32'(w_cmd), 0);
        step(0, 0, 0, 0);
        chk("min_up_time", 32'(w_time), pack(6, 14, 0));
        step(0, 1, 0, 0);
        chk("back_to_run", 32'(bus.mode), 0);
        chk("exit_set_cmds", 32'(w_cmd), SCE ? 9'b001_000_000 : 9'b0);
        step(0, 0, 0, 0);

        step(1, 0, 0, 0);
        chk("tick_a", 32'(w_cmd), 9'b110_000_000);
        step(1, 0, 0, 0);
        chk("tick_b_dropped", 32'(w_cmd), 0);
        step(0, 0, 0, 0);
        chk("tick_pair_sec", 32'(c_s), 1);
        step(1, 1, 0, 0);
        chk("mode_tick_cmds", 32'(w_cmd), 9'b110_000_000);
        chk("mode_tick_mode", 32'(bus.mode), 1);
        step(0, 0, 0, 0);
        chk("mode_tick_sec", 32'(c_s), 2);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        load(41, 20, 10);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("mode_x3_mode", 32'(bus.mode), 0);
        chk("mode_x3_cmds", 32'(w_cmd), SCE ? 9'b001_000_000 : 9'b0);
        step(0, 0, 0, 0);
        chk("mode_x3_time", 32'(w_time), pack(10, 20, SCE ? 0 : 41));

        mh = $urandom_range(0, 23);
        mm = $urandom_range(0, 59);
        ms = $urandom_range(0, 59);
        load(ms, mm, mh);
        step(0, 0, 0, 0);
        mmode = 0;
        mlock = 1'b0;
        for (int i = 0; i < 600; i++) begin
            t = ($urandom_range(0, 1) == 0);
            m = ($urandom_range(0, 7) == 0);
            u = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            prev = pack(mh, mm, ms);
            step(t, m, u, d);
            chk("rnd_time", 32'(w_time), prev);

            acc  = !mlock;
            mcmd = 1'b0;
            case (mmode)
                0: begin
                    if (t && acc) begin
                        tot = (mh * 3600 + mm * 60 + ms + 1) % 86400;
                        mh = tot / 3600;
                        mm = (tot / 60) % 60;
                        ms = tot % 60;
                        mcmd = 1'b1;
                    end
                    if (m) mmode = 1;
                end
                1: begin
                    if (m) mmode = 2;
                    else if (acc && (u != d)) begin
                        if (u) begin
                            mh = (mh + 1) % 24;
                            mcmd = 1'b1;
                        end else if (mh > 0) begin
                            mh = mh - 1;
                            mcmd = 1'b1;
                        end
                    end
                end
                default: begin
                    if (m) begin
                        mmode = 0;
                        if (SCE) begin
                            ms = 0;
                            mcmd = 1'b1;
                        end
                    end else if (acc && (u != d)) begin
                        if (u) begin
                            mm = (mm + 1) % 60;
                            mcmd = 1'b1;
                        end else if (mm > 0) begin
                            mm = mm - 1;
                            mcmd = 1'b1;
                        end
                    end
                end
            endcase
            mlock = mcmd;
            chk("rnd_mode", 32'(bus.mode), 32'(mmode));
            chk("rnd_cmd_issued", 32'(|w_cmd), 32'(mcmd));
        end
        step(0, 0, 0, 0);
        chk("rnd_final_time", 32'(w_time), pack(mh, mm, ms));

        step(0, 0, 0, 0);
        if (bus.mode == 2'd0) step(0, 1, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0);
        chk("midrst_mode", 32'(bus.mode), 0);
        chk("midrst_cmds", 32'(w_cmd), 0);
        rst = 1'b0;
        step(0, 0, 0, 0);
        chk("midrst_clr", 32'(w_cmd), 9'b001_001_001);
        step(0, 0, 0, 0);
        chk("midrst_time", 32'(w_time), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
